// File: rtl/decode_frame_loader.sv
// Frame loader: accepts a valid/ready word stream and writes one frame into a
// 2**ASIZE-word RAM. Optional frame_xor output is enabled by DECODE_FRAME_LOADER_XOR_EN.
module decode_frame_loader #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             wec,
    output logic [ASIZE-1:0] addrc,
    output logic [DSIZE-1:0] dinc,
    output logic             frame_valid,
    output logic [ASIZE:0]   frame_len,
    output logic             frame_ovf,
    input  logic             frame_ack
`ifdef DECODE_FRAME_LOADER_XOR_EN
    ,
    output logic [DSIZE-1:0] frame_xor
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FLUSH, HOLD} state_t;

    localparam logic [ASIZE-1:0] ADDR_MAX = '1;
    localparam logic [ASIZE:0]   LEN_MAX  = {1'b1, {ASIZE{1'b0}}};

    state_t           state, state_nxt;
    logic [ASIZE-1:0] addr;
    logic             accept;
    logic             write;
    logic             release_frame;

    always_comb begin
        // rst_n gates in_ready so upstream sees 0 for the whole reset pulse
        in_ready      = rst_n && (state == IDLE || state == LOAD || state == DRAIN);
        accept        = in_valid && in_ready;
        write         = accept && (state == IDLE || state == LOAD);
        release_frame = frame_valid && frame_ack;
        state_nxt     = state;
        case (state)
            IDLE:  if (accept) state_nxt = in_last ? FLUSH : LOAD;
            LOAD: begin
                if (accept) begin
                    if (in_last)               state_nxt = FLUSH;
                    else if (addr == ADDR_MAX) state_nxt = DRAIN;
                end
            end
            DRAIN: if (accept && in_last) state_nxt = FLUSH;
            FLUSH: state_nxt = HOLD;
            HOLD:  if (release_frame) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            wec         <= 1'b0;
            addrc       <= '0;
            dinc        <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            frame_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            wec   <= write;
            if (write) begin
                addrc <= addr;
                dinc  <= in_data;
            end
            // Address parks at the top slot instead of wrapping; cleared on release
            if (release_frame)
                addr <= '0;
            else if (write && addr != ADDR_MAX)
                addr <= addr + 1'b1;

            if (release_frame)
                frame_len <= '0;
            else if (write && frame_len != LEN_MAX)
                frame_len <= frame_len + 1'b1;

            if (release_frame)
                frame_ovf <= 1'b0;
            else if (state == LOAD && state_nxt == DRAIN)
                frame_ovf <= 1'b1;

            if (release_frame)
                frame_valid <= 1'b0;
            else if (state == FLUSH)
                frame_valid <= 1'b1;
        end
    end

`ifdef DECODE_FRAME_LOADER_XOR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_xor <= '0;
        else if (release_frame)
            frame_xor <= '0;
        else if (write)
            frame_xor <= frame_xor ^ in_data;
    end
`endif

endmodule

// File: tb/tb_decode_frame_loader.sv
// Scoreboard bench for decode_frame_loader (ASIZE=4): driver queues expected
// writes/frame results, a negedge monitor pops and compares them.
module tb_decode_frame_loader;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int CAP   = 1 << ASIZE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [DSIZE-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             wec;
    logic [ASIZE-1:0] addrc;
    logic [DSIZE-1:0] dinc;
    logic             frame_valid;
    logic [ASIZE:0]   frame_len;
    logic             frame_ovf;
    logic             frame_ack;
`ifdef DECODE_FRAME_LOADER_XOR_EN
    logic [DSIZE-1:0] frame_xor;
`endif

    decode_frame_loader #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wec        (wec),
        .addrc      (addrc),
        .dinc       (dinc),
        .frame_valid(frame_valid),
        .frame_len  (frame_len),
        .frame_ovf  (frame_ovf),
        .frame_ack  (frame_ack)
`ifdef DECODE_FRAME_LOADER_XOR_EN
        ,
        .frame_xor  (frame_xor)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [ASIZE-1:0] a; logic [DSIZE-1:0] d; } wr_t;
    typedef struct { int len; logic ovf; logic [DSIZE-1:0] x; } fr_t;

    wr_t wq[$];
    fr_t fq[$];
    logic [DSIZE-1:0] fw[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int  cd = 0;
    bit  prev_acc = 0;
    bit  prev_rel = 0;
    wr_t w;
    fr_t f;

    always @(negedge clk) begin
        if (!rst_n) begin
            cd = 0; prev_acc = 0; prev_rel = 0;
        end else begin
            if (wec) begin
                check("write_after_accept", {31'd0, prev_acc}, 32'd1);
                if (wq.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else begin
                    w = wq.pop_front();
                    check("addrc", {28'd0, addrc}, {28'd0, w.a});
                    check("dinc", {24'd0, dinc}, {24'd0, w.d});
                end
            end
            if (frame_valid) check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            if (prev_rel) begin
                check("ack_fv_clear", {31'd0, frame_valid}, 32'd0);
                check("ack_len_clear", {27'd0, frame_len}, 32'd0);
                check("ack_ovf_clear", {31'd0, frame_ovf}, 32'd0);
            end
            if (cd > 0) begin
                cd--;
                if (cd == 1) check("fv_early", {31'd0, frame_valid}, 32'd0);
                if (cd == 0) begin
                    check("fv_rise", {31'd0, frame_valid}, 32'd1);
                    if (fq.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
                    else begin
                        f = fq.pop_front();
                        check("frame_len", {27'd0, frame_len}, f.len);
                        check("frame_ovf", {31'd0, frame_ovf}, {31'd0, f.ovf});
`ifdef DECODE_FRAME_LOADER_XOR_EN
                        check("frame_xor", {24'd0, frame_xor}, {24'd0, f.x});
`endif
                    end
                end
            end
            if (in_valid && in_ready && in_last) cd = 2;
            prev_acc = in_valid && in_ready;
            prev_rel = frame_valid && frame_ack;
        end
    end

    // ---------------- driver ----------------
    task automatic send_beat(input logic [DSIZE-1:0] d, input logic last);
        bit ok = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        check("beat_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Sends fw[] as one frame, waits for frame_valid, optionally pushes junk into HOLD, then acks.
    task automatic send_frame(input int maxgap, input int hold, input bit bogus_ack);
        int n = fw.size();
        int nw = (n > CAP) ? CAP : n;
        logic [DSIZE-1:0] x = '0;
        bit got = 0;
        for (int i = 0; i < nw; i++) begin
            wq.push_back('{a: i[ASIZE-1:0], d: fw[i]});
            x ^= fw[i];
        end
        fq.push_back('{len: nw, ovf: (n > CAP), x: x});
        if (bogus_ack) begin
            frame_ack = 1'b1; idle_cycles(1); frame_ack = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            send_beat(fw[i], i == n - 1);
            if (maxgap > 0) idle_cycles($urandom_range(0, maxgap));
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (frame_valid) begin got = 1; break; end
        end
        check("frame_timeout", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        if (hold > 0) begin
            in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
            idle_cycles(hold);
            in_valid = 1'b0; in_last = 1'b0;
        end
        frame_ack = 1'b1;
        idle_cycles(1);
        frame_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_wec"}, {31'd0, wec}, 32'd0);
        check({tag, "_addrc"}, {28'd0, addrc}, 32'd0);
        check({tag, "_dinc"}, {24'd0, dinc}, 32'd0);
        check({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_len"}, {27'd0, frame_len}, 32'd0);
        check({tag, "_ovf"}, {31'd0, frame_ovf}, 32'd0);
`ifdef DECODE_FRAME_LOADER_XOR_EN
        check({tag, "_xor"}, {24'd0, frame_xor}, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; frame_ack = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // three-word frame, continuous, with an ack pulse that must be ignored
        fw = '{8'h11, 8'h22, 8'h33};
        send_frame(0, 0, 1);
        // single-word frame, then HOLD stuffed with valid for 10 cycles
        fw = '{8'hA5};
        send_frame(0, 10, 0);
        fw = '{8'h5A, 8'h3C};
        send_frame(0, 0, 0);
        // exactly full, then one over, then 20 words
        fw.delete();
        for (int i = 0; i < CAP; i++) fw.push_back(8'(i * 7 + 1));
        send_frame(0, 0, 0);
        fw.push_back(8'hC3);
        send_frame(0, 2, 0);
        fw.delete();
        for (int i = 1; i <= 20; i++) fw.push_back(8'(i));
        send_frame(1, 0, 0);

        // reset after 5 of 8 words
        for (int i = 0; i < 5; i++) wq.push_back('{a: i[ASIZE-1:0], d: 8'(8'h40 + i)});
        for (int i = 0; i < 5; i++) send_beat(8'(8'h40 + i), 1'b0);
        idle_cycles(2);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst1");
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("rel1_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        fw = '{8'h77, 8'h88};
        send_frame(0, 0, 0);

        // random lengths and gaps
        for (int k = 0; k < 100; k++) begin
            int n = $urandom_range(1, 20);
            fw.delete();
            for (int i = 0; i < n; i++) fw.push_back(8'($urandom));
            send_frame(3, $urandom_range(0, 2), 1'b0);
        end

        idle_cycles(4);
        check("wq_empty", wq.size(), 32'd0);
        check("fq_empty", fq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_frame_loader.md
DECODE_FRAME_LOADER -- requirements
Module: decode_frame_loader

Interface
REQ-001 Parameter DSIZE, default 8, data word width; SHALL equal the DSIZE of the attached frame RAM.
REQ-002 Parameter ASIZE, default 10, RAM address width; frame capacity SHALL be 2**ASIZE words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  DSIZE  upstream word.
REQ-007 in_last  input  1  marks final word of frame; qualified by in_valid.
REQ-008 in_ready  output  1  loader can accept a word.
REQ-009 wec  output  1  RAM write enable.
REQ-010 addrc  output  ASIZE  RAM write address.
REQ-011 dinc  output  DSIZE  RAM write data.
REQ-012 frame_valid  output  1  complete frame resident in RAM.
REQ-013 frame_len  output  ASIZE+1  number of words stored, 1..2**ASIZE.
REQ-014 frame_ovf  output  1  frame exceeded capacity and was truncated.
REQ-015 frame_ack  input  1  consumer releases frame; qualified by frame_valid.

Function
REQ-016 A beat SHALL be accepted in any cycle with in_valid=1 and in_ready=1.
REQ-017 States SHALL be IDLE, LOAD, DRAIN, FLUSH, HOLD; in_ready SHALL be 1 in IDLE, LOAD and DRAIN and 0 in FLUSH and HOLD.
REQ-018 IDLE: an accepted beat SHALL move to LOAD, or to FLUSH if in_last=1; the write address SHALL start at 0.
REQ-019 Each accepted beat in IDLE/LOAD SHALL register wec=1, addrc=current address, dinc=in_data one cycle later, then increment the address; wec SHALL be 0 in every other cycle.
REQ-020 LOAD: an accepted beat with in_last=1 SHALL move to FLUSH; an accepted beat writing address 2**ASIZE-1 with in_last=0 SHALL move to DRAIN.
REQ-021 DRAIN: accepted beats SHALL NOT be written; frame_ovf SHALL be set; an accepted beat with in_last=1 SHALL move to FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle, then move to HOLD; with the last write at cycle N+1, frame_valid SHALL rise at cycle N+2, where N is the last-beat acceptance cycle.
REQ-023 HOLD: frame_valid=1, frame_len and frame_ovf SHALL be stable; frame_ack=1 SHALL clear frame_valid, frame_ovf and frame_len on the next edge and return to IDLE.
REQ-024 frame_ack while frame_valid=0 SHALL be ignored.
REQ-025 frame_len SHALL count written words only and saturate at 2**ASIZE; its width of ASIZE+1 SHALL prevent wrap.
REQ-026 The address counter SHALL never wrap within a frame; no RAM location SHALL be written twice per frame.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, in_ready=0 while asserted, wec=0, addrc=0, dinc=0, frame_valid=0, frame_len=0, frame_ovf=0 and, when compiled in, frame_xor=0.
REQ-028 Reset mid-frame SHALL discard the partial frame without clearing RAM contents; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-029 With macro DECODE_FRAME_LOADER_XOR_EN defined, output frame_xor (DSIZE bits) SHALL hold the XOR of all written words of the frame; it SHALL be valid with frame_valid and cleared on frame_ack.
REQ-030 Without DECODE_FRAME_LOADER_XOR_EN, the frame_xor port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Frame 0x11,0x22,0x33 (last on 0x33), in_valid continuous -> writes at addr 0,1,2; frame_valid two cycles after the 0x33 acceptance; frame_len=3; frame_ovf=0; frame_xor=0x00.
REQ-032 Single-word frame 0xA5 with in_last=1 -> one write at addr 0; frame_len=1; frame_xor=0xA5.
REQ-033 ASIZE=4, 20 words with last on word 20 -> 16 writes at addr 0..15; words 17..20 not written; frame_len=16; frame_ovf=1.
REQ-034 In HOLD, in_valid=1 held for 10 cycles -> in_ready=0, no writes; pulse frame_ack -> frame_valid=0 next cycle; next beat is written at addr 0.
REQ-035 rst_n pulsed low after 5 of 8 words -> all outputs at reset values; a new 2-word frame gives frame_len=2 at addr 0..1.
REQ-036 Random in_valid gaps over 100 frames -> each frame_len matches the beat count; no write in a cycle following a beat with in_ready=0.
